// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter (with helper wb_arbiter_fifo)
//  Description : Write-back arbiter merging ALU and LSU results into a single
//                register-file write port. Each source has a 2-entry skid
//                FIFO. LSU wins by default and a saturating starvation counter
//                guarantees ALU progress. Illegal destinations are consumed
//                silently and flagged with a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Two-entry FIFO holding {rd_addr, data}. Ready is a registered copy of
// (count < 2), so it never depends combinationally on the valid input.
// ----------------------------------------------------------------------------
module wb_arbiter_fifo #(
    parameter int AW = 4,
    parameter int DW = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [AW-1:0]      i_addr,
    input  logic [DW-1:0]      i_data,
    output logic               o_ready,
    input  logic               i_pop,
    output logic               o_has,
    output logic [AW-1:0]      o_head_addr,
    output logic [DW-1:0]      o_head_data,
    output logic [1:0]         o_slot_vld,
    output logic [1:0][AW-1:0] o_slot_addr
);
    logic [1:0][AW-1:0] r_addr;
    logic [1:0][DW-1:0] r_data;
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_cnt;
    logic               r_ready;
    logic [1:0]         w_cnt_nxt;
    logic               w_push;

    assign w_push = i_valid & r_ready;

    // Occupancy after this edge: push and pop together leave it unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, i_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointer/count/ready state; pointers are 1 bit so they wrap modulo 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt < 2'd2);
        end
    end

    // Entry storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= i_addr;
            r_data[r_wptr] <= i_data;
        end
    end

    assign o_ready     = r_ready;
    assign o_has       = (r_cnt != 2'd0);
    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_slot_addr = r_addr;
    // Slot at the read pointer is live when non-empty; the other only when full.
    assign o_slot_vld[0] = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && (r_rptr == 1'b0));
    assign o_slot_vld[1] = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && (r_rptr == 1'b1));
endmodule

// ----------------------------------------------------------------------------
// Top: two FIFOs, fixed-priority arbiter with starvation override, output
// register and combinational pending-write mask.
// ----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN                = 64,
    parameter int REG_FILE_ADDR_WIDTH = 4,
    parameter int REG_FILE_DEPTH      = 11,
    parameter int STARVE_LIMIT        = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_wb_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_wb_rd_addr,
    input  logic [XLEN-1:0]                alu_wb_data,
    output logic                           alu_wb_ready,
    input  logic                           lsu_wb_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] lsu_wb_rd_addr,
    input  logic [XLEN-1:0]                lsu_wb_data,
    output logic                           lsu_wb_ready,
    output logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]                rd_data,
    output logic                           rd_wr_en,
    output logic [REG_FILE_DEPTH-1:0]      wb_pending,
    output logic                           wb_illegal
);
    localparam int c_AW  = REG_FILE_ADDR_WIDTH;
    localparam int c_SW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    // r10 is the read-only frame pointer.
    localparam int c_FP_REG = 10;

    // Writable architectural register: inside the file and not the frame pointer.
    function automatic logic f_legal(input logic [c_AW-1:0] a);
        return (int'(a) != c_FP_REG) && (int'(a) < REG_FILE_DEPTH);
    endfunction

    logic                   w_alu_has, w_lsu_has;
    logic                   w_alu_win, w_lsu_win, w_grant;
    logic [c_AW-1:0]        w_alu_head_addr, w_lsu_head_addr;
    logic [XLEN-1:0]        w_alu_head_data, w_lsu_head_data;
    logic [1:0]             w_alu_slot_vld, w_lsu_slot_vld;
    logic [1:0][c_AW-1:0]   w_alu_slot_addr, w_lsu_slot_addr;
    logic [c_AW-1:0]        w_g_addr;
    logic [XLEN-1:0]        w_g_data;
    logic [c_SW-1:0]        r_starve;
    logic [c_AW-1:0]        r_rd_addr;
    logic [XLEN-1:0]        r_rd_data;
    logic                   r_rd_wr_en;
    logic                   r_illegal;

    wb_arbiter_fifo #(.AW(c_AW), .DW(XLEN)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (alu_wb_valid),
        .i_addr      (alu_wb_rd_addr),
        .i_data      (alu_wb_data),
        .o_ready     (alu_wb_ready),
        .i_pop       (w_alu_win),
        .o_has       (w_alu_has),
        .o_head_addr (w_alu_head_addr),
        .o_head_data (w_alu_head_data),
        .o_slot_vld  (w_alu_slot_vld),
        .o_slot_addr (w_alu_slot_addr)
    );

    wb_arbiter_fifo #(.AW(c_AW), .DW(XLEN)) u_lsu_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (lsu_wb_valid),
        .i_addr      (lsu_wb_rd_addr),
        .i_data      (lsu_wb_data),
        .o_ready     (lsu_wb_ready),
        .i_pop       (w_lsu_win),
        .o_has       (w_lsu_has),
        .o_head_addr (w_lsu_head_addr),
        .o_head_data (w_lsu_head_data),
        .o_slot_vld  (w_lsu_slot_vld),
        .o_slot_addr (w_lsu_slot_addr)
    );

    // Grant: LSU by default, ALU when alone or when it has lost too often.
    always_comb begin
        w_alu_win = w_alu_has && (!w_lsu_has || (r_starve == c_STARVE_MAX));
        w_lsu_win = w_lsu_has && !w_alu_win;
        w_grant   = w_alu_win || w_lsu_win;
        w_g_addr  = w_alu_win ? w_alu_head_addr : w_lsu_head_addr;
        w_g_data  = w_alu_win ? w_alu_head_data : w_lsu_head_data;
    end

    // Starvation counter: counts consecutive ALU losses, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_alu_has && w_lsu_win) begin
            if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    // Output register: granted entry becomes a write or an illegal pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_rd_wr_en <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_grant) begin
            r_rd_addr  <= w_g_addr;
            r_rd_data  <= w_g_data;
            r_rd_wr_en <= f_legal(w_g_addr);
            r_illegal  <= !f_legal(w_g_addr);
        end else begin
            r_rd_wr_en <= 1'b0;
            r_illegal  <= 1'b0;
        end
    end

    assign rd_addr    = r_rd_addr;
    assign rd_data    = r_rd_data;
    assign rd_wr_en   = r_rd_wr_en;
    assign wb_illegal = r_illegal;

    // Pending mask: any live FIFO slot or an in-flight write targeting reg i.
    for (genvar gi = 0; gi < REG_FILE_DEPTH; gi++) begin : g_pending
        localparam logic [c_AW-1:0] c_IDX = c_AW'(gi);
        if (gi == c_FP_REG) begin : g_ro
            assign wb_pending[gi] = 1'b0;
        end else begin : g_rw
            assign wb_pending[gi] =
                (w_alu_slot_vld[0] && (w_alu_slot_addr[0] == c_IDX)) ||
                (w_alu_slot_vld[1] && (w_alu_slot_addr[1] == c_IDX)) ||
                (w_lsu_slot_vld[0] && (w_lsu_slot_addr[0] == c_IDX)) ||
                (w_lsu_slot_vld[1] && (w_lsu_slot_addr[1] == c_IDX)) ||
                (r_rd_wr_en && (r_rd_addr == c_IDX));
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: queue-based reference
//                model compared every cycle, directed scenarios with literal
//                expectations, then randomized traffic with sporadic resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    localparam int XLEN   = 64;
    localparam int AW     = 4;
    localparam int DEPTH  = 11;
    localparam int STARVE = 4;

    typedef struct packed {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } ent_t;

    logic              clk;
    logic              rst;
    logic              alu_wb_valid;
    logic [AW-1:0]     alu_wb_rd_addr;
    logic [XLEN-1:0]   alu_wb_data;
    logic              alu_wb_ready;
    logic              lsu_wb_valid;
    logic [AW-1:0]     lsu_wb_rd_addr;
    logic [XLEN-1:0]   lsu_wb_data;
    logic              lsu_wb_ready;
    logic [AW-1:0]     rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic              rd_wr_en;
    logic [DEPTH-1:0]  wb_pending;
    logic              wb_illegal;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    wb_arbiter #(
        .XLEN(XLEN), .REG_FILE_ADDR_WIDTH(AW),
        .REG_FILE_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd_addr(alu_wb_rd_addr),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd_addr(lsu_wb_rd_addr),
        .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_wr_en(rd_wr_en),
        .wb_pending(wb_pending), .wb_illegal(wb_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t            aq[$];
    ent_t            lq[$];
    int              m_starve = 0;
    bit              m_ar = 1'b0, m_lr = 1'b0, m_we = 1'b0, m_ill = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [XLEN-1:0] m_data = '0;
    bit              m_a_has, m_l_has, m_gv;
    ent_t            m_g;

    function automatic bit m_legal(input logic [AW-1:0] a);
        return (a != 4'd10) && (a < 4'd11);
    endfunction

    function automatic logic [DEPTH-1:0] m_pending();
        logic [15:0] p;
        p = '0;
        foreach (aq[k]) if (m_legal(aq[k].a)) p[aq[k].a] = 1'b1;
        foreach (lq[k]) if (m_legal(lq[k].a)) p[lq[k].a] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        return p[DEPTH-1:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            aq.delete();
            lq.delete();
            m_starve = 0;
            m_ar = 1'b0; m_lr = 1'b0; m_we = 1'b0; m_ill = 1'b0;
            m_addr = '0; m_data = '0;
        end else begin
            m_a_has = (aq.size() != 0);
            m_l_has = (lq.size() != 0);
            m_gv    = 1'b0;
            if (m_a_has && (!m_l_has || m_starve == STARVE)) begin
                m_g = aq.pop_front(); m_gv = 1'b1; m_starve = 0;
            end else if (m_l_has) begin
                m_g = lq.pop_front(); m_gv = 1'b1;
                m_starve = m_a_has ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
            end else begin
                m_starve = 0;
            end
            if (m_gv) begin
                m_addr = m_g.a; m_data = m_g.d;
                m_we = m_legal(m_g.a); m_ill = !m_legal(m_g.a);
            end else begin
                m_we = 1'b0; m_ill = 1'b0;
            end
            if (alu_wb_valid && m_ar) aq.push_back({alu_wb_rd_addr, alu_wb_data});
            if (lsu_wb_valid && m_lr) lq.push_back({lsu_wb_rd_addr, lsu_wb_data});
            m_ar = (aq.size() < 2);
            m_lr = (lq.size() < 2);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_wb_ready", {63'd0, alu_wb_ready}, {63'd0, m_ar});
            chk("lsu_wb_ready", {63'd0, lsu_wb_ready}, {63'd0, m_lr});
            chk("rd_wr_en", {63'd0, rd_wr_en}, {63'd0, m_we});
            chk("wb_illegal", {63'd0, wb_illegal}, {63'd0, m_ill});
            chk("rd_addr", {60'd0, rd_addr}, {60'd0, m_addr});
            chk("rd_data", rd_data, m_data);
            chk("wb_pending", {53'd0, wb_pending}, {53'd0, m_pending()});
        end
    end

    task automatic idle(input int n);
        alu_wb_valid = 1'b0;
        lsu_wb_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int n_lsu, ill_cnt, we_cnt, n;
    bit seen;

    initial begin
        rst = 1'b1;
        alu_wb_valid = 1'b0; alu_wb_rd_addr = '0; alu_wb_data = '0;
        lsu_wb_valid = 1'b0; lsu_wb_rd_addr = '0; lsu_wb_data = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        // Reset values
        chk("rst_rd_wr_en", {63'd0, rd_wr_en}, 64'd0);
        chk("rst_rd_addr", {60'd0, rd_addr}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_wb_illegal", {63'd0, wb_illegal}, 64'd0);
        chk("rst_alu_ready", {63'd0, alu_wb_ready}, 64'd0);
        chk("rst_lsu_ready", {63'd0, lsu_wb_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst_alu", {63'd0, alu_wb_ready}, 64'd1);
        chk("ready_after_rst_lsu", {63'd0, lsu_wb_ready}, 64'd1);

        // Single ALU write to r3, two-cycle latency
        idle(2);
        alu_wb_valid = 1'b1; alu_wb_rd_addr = 4'd3; alu_wb_data = 64'h1122334455667788;
        @(negedge clk);
        alu_wb_valid = 1'b0;
        chk("single_pend_queued", {63'd0, wb_pending[3]}, 64'd1);
        chk("single_no_early_wr", {63'd0, rd_wr_en}, 64'd0);
        @(negedge clk);
        chk("single_wr_en", {63'd0, rd_wr_en}, 64'd1);
        chk("single_addr", {60'd0, rd_addr}, 64'd3);
        chk("single_data", rd_data, 64'h1122334455667788);
        chk("single_pend_wr", {63'd0, wb_pending[3]}, 64'd1);
        @(negedge clk);
        chk("single_wr_done", {63'd0, rd_wr_en}, 64'd0);
        chk("single_pend_clear", {53'd0, wb_pending}, 64'd0);

        // Simultaneous offers: LSU first
        idle(2);
        alu_wb_valid = 1'b1; alu_wb_rd_addr = 4'd1; alu_wb_data = 64'hA;
        lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 4'd2; lsu_wb_data = 64'hB;
        @(negedge clk);
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        @(negedge clk);
        chk("both_first_addr", {60'd0, rd_addr}, 64'd2);
        chk("both_first_data", rd_data, 64'hB);
        @(negedge clk);
        chk("both_second_wr", {63'd0, rd_wr_en}, 64'd1);
        chk("both_second_addr", {60'd0, rd_addr}, 64'd1);
        chk("both_second_data", rd_data, 64'hA);

        // Starvation: ALU granted after exactly STARVE LSU grants
        idle(3);
        alu_wb_valid = 1'b1; alu_wb_rd_addr = 4'd7; alu_wb_data = 64'd77;
        lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 4'd5; lsu_wb_data = 64'd1000;
        @(negedge clk);
        alu_wb_valid = 1'b0;
        n_lsu = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (rd_wr_en && rd_addr == 4'd7) seen = 1'b1;
            else if (rd_wr_en && rd_addr == 4'd5) n_lsu++;
            if (!seen) begin
                lsu_wb_data = lsu_wb_data + 64'd1;
                @(negedge clk);
            end
        end
        chk("starve_alu_seen", {63'd0, seen}, 64'd1);
        chk("starve_lsu_grants", 64'(n_lsu), 64'(STARVE));

        // ALU backpressure with LSU keeping the arbiter busy
        idle(6);
        lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 4'd4; lsu_wb_data = 64'd500;
        @(negedge clk);
        alu_wb_valid = 1'b1; alu_wb_rd_addr = 4'd6; alu_wb_data = 64'hA1;
        lsu_wb_data = 64'd501;
        @(negedge clk);
        chk("bp_ready_after_1st", {63'd0, alu_wb_ready}, 64'd1);
        alu_wb_data = 64'hA2;
        @(negedge clk);
        chk("bp_ready_after_2nd", {63'd0, alu_wb_ready}, 64'd0);
        alu_wb_data = 64'hA3;
        n = 0;
        while (!alu_wb_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("bp_ready_low_cycles", 64'(n), 64'd4);
        @(negedge clk);
        alu_wb_valid = 1'b0;
        idle(8);

        // Illegal destinations r10 (LSU) and r12 (ALU)
        alu_wb_valid = 1'b1; alu_wb_rd_addr = 4'd12; alu_wb_data = 64'hDEAD;
        lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 4'd10; lsu_wb_data = 64'hBEEF;
        @(negedge clk);
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        chk("ill_pending_zero", {53'd0, wb_pending}, 64'd0);
        ill_cnt = 0; we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ill_cnt += int'(wb_illegal);
            we_cnt  += int'(rd_wr_en);
        end
        chk("ill_pulses", 64'(ill_cnt), 64'd2);
        chk("ill_writes", 64'(we_cnt), 64'd0);
        chk("ill_drain_alu", {63'd0, alu_wb_ready}, 64'd1);
        chk("ill_drain_lsu", {63'd0, lsu_wb_ready}, 64'd1);

        // Mid-operation reset with entries queued
        alu_wb_valid = 1'b1; alu_wb_rd_addr = 4'd1;
        lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 4'd2;
        for (int c = 0; c < 6; c++) begin
            alu_wb_data = 64'(c + 100); lsu_wb_data = 64'(c + 200);
            @(negedge clk);
        end
        chk("mrst_pending_before", {63'd0, |wb_pending}, 64'd1);
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("mrst_wr_en", {63'd0, rd_wr_en}, 64'd0);
            chk("mrst_pending", {53'd0, wb_pending}, 64'd0);
            chk("mrst_alu_ready", {63'd0, alu_wb_ready}, 64'd0);
            chk("mrst_lsu_ready", {63'd0, lsu_wb_ready}, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_alu_ready_up", {63'd0, alu_wb_ready}, 64'd1);
        chk("mrst_lsu_ready_up", {63'd0, lsu_wb_ready}, 64'd1);
        chk("mrst_no_write", {63'd0, rd_wr_en}, 64'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            alu_wb_valid   = ($urandom_range(0, 9) < 6);
            alu_wb_rd_addr = 4'($urandom_range(0, 15));
            alu_wb_data    = {$urandom, $urandom};
            lsu_wb_valid   = ($urandom_range(0, 9) < 7);
            lsu_wb_rd_addr = 4'($urandom_range(0, 15));
            lsu_wb_data    = {$urandom, $urandom};
            @(negedge clk);
        end
        rst = 1'b0;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
